// File: rtl/ch_start_sequencer.sv
// Fires fast sampling banks one group at a time off a synchronised start pulse.
// Build option: define CH_START_TIMEOUT_EN to include the per-group watchdog and its abort path.
module ch_start_sequencer #(
  parameter int NUM_BANKS = 4,
  parameter int MODE_W    = 2,
  parameter int TO_W      = 16,
  localparam int GI_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 INST_START,
  input  logic [MODE_W-1:0]    MODE,
  input  logic [NUM_BANKS-1:0] bank_done,
  input  logic [TO_W-1:0]      timeout_cycles,
  output logic [NUM_BANKS-1:0] bank_start,
  output logic                 busy,
  output logic                 seq_done,
  output logic [GI_W-1:0]      group_idx,
  output logic                 timeout_err
);

  localparam int LOG_NB = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, DONE} state_t;

  // log2 of the group size; modes asking for more banks than exist use all of them
  function automatic int group_log2(input logic [MODE_W-1:0] m);
    return (int'(m) > LOG_NB) ? LOG_NB : int'(m);
  endfunction

  function automatic logic [NUM_BANKS-1:0] group_mask(input logic [MODE_W-1:0] m,
                                                      input logic [GI_W-1:0]   idx);
    logic [NUM_BANKS-1:0] mask;
    int lg;
    mask = '0;
    lg   = group_log2(m);
    for (int b = 0; b < NUM_BANKS; b++) mask[b] = ((b >> lg) == int'(idx));
    return mask;
  endfunction

  function automatic logic last_group(input logic [MODE_W-1:0] m, input logic [GI_W-1:0] idx);
    return int'(idx) == ((NUM_BANKS >> group_log2(m)) - 1);
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           sync_q;
  logic                 edge_q;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [GI_W-1:0]      group_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d, cur_mask, bank_start_d;
  logic                 err_d;
  logic                 expire;

  // Two flops for metastability, the third holds the previous level for edge detection.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], INST_START};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

`ifdef CH_START_TIMEOUT_EN
  logic [TO_W-1:0] wd_q;

  // Holds the number of cycles since FIRE, counting FIRE and the current cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q <= '0;
    end else if (state_q == FIRE) begin
      wd_q <= TO_W'(2);
    end else if (state_q == WAIT && wd_q != '1) begin
      wd_q <= wd_q + TO_W'(1);
    end
  end

  assign expire = (timeout_cycles != '0) && (wd_q >= timeout_cycles);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign expire         = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    group_d  = group_idx;
    err_d    = timeout_err;
    mask_d   = '0;
    cur_mask = group_mask(mode_q, group_idx);
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          state_d = FIRE;
          mode_d  = MODE;
          group_d = '0;
          err_d   = 1'b0;
        end
      end
      FIRE: begin
        mask_d  = bank_done & cur_mask;
        state_d = WAIT;
      end
      WAIT: begin
        mask_d = mask_q | (bank_done & cur_mask);
        if (mask_q == cur_mask) begin
          if (last_group(mode_q, group_idx)) begin
            state_d = DONE;
          end else begin
            group_d = group_idx + GI_W'(1);
            state_d = FIRE;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it when registered.
    bank_start_d = (state_d == FIRE) ? group_mask(mode_d, group_d) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      group_idx   <= '0;
      mask_q      <= '0;
      timeout_err <= 1'b0;
      bank_start  <= '0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      group_idx   <= group_d;
      mask_q      <= mask_d;
      timeout_err <= err_d;
      bank_start  <= bank_start_d;
      busy        <= (state_d != IDLE);
      seq_done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_ch_start_sequencer.sv
// Self-checking bench for ch_start_sequencer: table of start vectors plus hand-written corner cases,
// with a scoreboard of expected bank_start pulses and seq_done cycles.
module tb_ch_start_sequencer;
  localparam int NB  = 4;
  localparam int BIG = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rstn;
  logic          INST_START;
  logic [1:0]    MODE;
  logic [NB-1:0] bank_done;
  logic [15:0]   timeout_cycles;
  logic [NB-1:0] bank_start;
  logic          busy;
  logic          seq_done;
  logic [1:0]    group_idx;
  logic          timeout_err;

  ch_start_sequencer #(.NUM_BANKS(NB), .MODE_W(2), .TO_W(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .INST_START     (INST_START),
    .MODE           (MODE),
    .bank_done      (bank_done),
    .timeout_cycles (timeout_cycles),
    .bank_start     (bank_start),
    .busy           (busy),
    .seq_done       (seq_done),
    .group_idx      (group_idx),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB-1:0] pat;
    int            cyc;
    int            grp;
  } pulse_t;

  typedef struct {
    int            mode;
    int            dly;
    int            width;
    int            ng;
    logic [NB-1:0] first;
  } vec_t;

  pulse_t        pulse_q[$];
  int            done_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pulses = 0;
  int            n_done   = 0;
  logic [NB-1:0] first_pat;
  int            dly [NB];
  int            bz_from [2];
  int            bz_to [2];
  int            err_on, err_off;
  logic [NB-1:0] resp_done, stray;
  vec_t          tbl [5];

  assign bank_done = resp_done | stray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_busy(input int c);
    return (c >= bz_from[0] && c <= bz_to[0]) || (c >= bz_from[1] && c <= bz_to[1]);
  endfunction

  // Reference model: expected pulse schedule for a start driven at negedge e0.
  task automatic push_model(input int mode, input int to, input int e0, output int done_cyc);
    int lg, g_sz, ng, f, m, done;
    bit never;
    pulse_t p;
    lg   = (mode > 2) ? 2 : mode;
    g_sz = 1 << lg;
    ng   = NB >> lg;
    f    = e0 + 4;
    done = 0;
    bz_from[0] = bz_from[1];
    bz_to[0]   = bz_to[1];
    bz_from[1] = f;
    if (err_off > f) err_off = f;
    for (int g = 0; g < ng; g++) begin
      p.pat = NB'(((1 << g_sz) - 1) << (g * g_sz));
      p.cyc = f;
      p.grp = g;
      pulse_q.push_back(p);
      m     = 0;
      never = 0;
      for (int b = g * g_sz; b < (g + 1) * g_sz; b++) begin
        if (dly[b] < 0) never = 1;
        else if (dly[b] > m) m = dly[b];
      end
      if (never) begin
        done    = f + to;
        err_on  = done;
        err_off = BIG;
        break;
      end
      f = f + m + 2;
      if (g == ng - 1) done = f;
    end
    done_q.push_back(done);
    bz_to[1] = done;
    done_cyc = done;
  endtask

  // Call just after a negedge.
  task automatic launch(input int mode, input int width, input int to, output int done_cyc);
    MODE           = 2'(mode);
    timeout_cycles = 16'(to);
    INST_START     = 1'b1;
    push_model(mode, to, cyc, done_cyc);
    repeat (width) @(negedge clk);
    INST_START = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (n_done < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("seq_done_seen", 32'(n_done >= target), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bank_start"}, 32'(bank_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_seq_done"}, 32'(seq_done), 0);
    check({tag, "_group_idx"}, 32'(group_idx), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic set_dly(input int d);
    for (int b = 0; b < NB; b++) dly[b] = d;
  endtask

  // Bank model: each started bank acks dly[b] cycles later; dly < 0 never acks.
  initial begin
    int     cnt [NB];
    bit     pend [NB];
    resp_done = '0;
    for (int b = 0; b < NB; b++) begin
      cnt[b]  = 0;
      pend[b] = 0;
    end
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (rstn !== 1'b1) begin
        for (int b = 0; b < NB; b++) pend[b] = 0;
      end else begin
        for (int b = 0; b < NB; b++)
          if (bank_start[b] && dly[b] >= 0) begin
            pend[b] = 1;
            cnt[b]  = dly[b];
          end
        for (int b = 0; b < NB; b++)
          if (pend[b]) begin
            if (cnt[b] == 0) begin
              resp_done[b] = 1'b1;
              pend[b]      = 0;
            end else begin
              cnt[b]--;
            end
          end
      end
    end
  end

  // Monitor: per-cycle busy/timeout_err windows, scoreboard pops on bank_start and seq_done.
  initial begin
    pulse_t e;
    int     dc;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        check("busy", 32'(busy), 32'(in_busy(cyc)));
        check("timeout_err", 32'(timeout_err), 32'(cyc >= err_on && cyc < err_off));
        if (bank_start != '0) begin
          n_pulses++;
          if (n_pulses == 1) first_pat = bank_start;
          if (pulse_q.size() == 0) begin
            check("extra_bank_start", 32'(bank_start), 0);
          end else begin
            e = pulse_q.pop_front();
            check("bank_start", 32'(bank_start), 32'(e.pat));
            check("bank_start_cycle", cyc, e.cyc);
            check("group_idx", 32'(group_idx), e.grp);
          end
        end
        if (seq_done) begin
          n_done++;
          if (done_q.size() == 0) begin
            check("extra_seq_done", 32'(seq_done), 0);
          end else begin
            dc = done_q.pop_front();
            check("seq_done_cycle", cyc, dc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int d0, d1, tgt;
    tbl[0] = '{mode: 0, dly: 5, width: 2, ng: 4, first: 4'b0001};
    tbl[1] = '{mode: 1, dly: 2, width: 3, ng: 2, first: 4'b0011};
    tbl[2] = '{mode: 2, dly: 0, width: 2, ng: 1, first: 4'b1111};
    tbl[3] = '{mode: 3, dly: 1, width: 4, ng: 1, first: 4'b1111};
    tbl[4] = '{mode: 0, dly: 0, width: 2, ng: 4, first: 4'b0001};

    rstn           = 1'b0;
    INST_START     = 1'b0;
    MODE           = '0;
    timeout_cycles = '0;
    stray          = '0;
    set_dly(5);
    err_on     = BIG;
    err_off    = BIG;
    bz_from[0] = 1; bz_to[0] = 0;
    bz_from[1] = 1; bz_to[1] = 0;

    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Table-driven sequences
    for (int i = 0; i < 5; i++) begin
      set_dly(tbl[i].dly);
      n_pulses = 0;
      tgt      = n_done + 1;
      @(negedge clk);
      launch(tbl[i].mode, tbl[i].width, 0, d0);
      wait_done(tgt);
      check("num_groups", n_pulses, tbl[i].ng);
      check("first_pattern", 32'(first_pat), 32'(tbl[i].first));
    end

    // MODE 1: bank 1 acks in FIRE, bank 0 three cycles later, stray bank 3 ack during group 0
    dly[0] = 3; dly[1] = 0; dly[2] = 2; dly[3] = 2;
    n_pulses = 0;
    tgt      = n_done + 1;
    @(negedge clk);
    d1 = cyc + 5;
    launch(1, 2, 0, d0);
    while (cyc < d1) @(negedge clk);
    stray = 4'b1000;
    @(negedge clk);
    stray = '0;
    wait_done(tgt);
    check("mode1_groups", n_pulses, 2);

    // Start while busy is dropped; start in first IDLE cycle after DONE is accepted
    set_dly(5);
    n_pulses = 0;
    tgt      = n_done + 2;
    @(negedge clk);
    d1 = cyc + 10;
    launch(0, 2, 0, d0);
    while (cyc < d1) @(negedge clk);
    INST_START = 1'b1;
    repeat (2) @(negedge clk);
    INST_START = 1'b0;
    while (cyc < d0 - 2) @(negedge clk);
    set_dly(2);
    launch(0, 2, 0, d1);
    wait_done(tgt);
    check("restart_groups", n_pulses, 8);

    // Slow acks with the watchdog disabled never abort
    set_dly(30);
    n_pulses = 0;
    tgt      = n_done + 1;
    @(negedge clk);
    launch(2, 2, 0, d0);
    wait_done(tgt);
    check("slow_no_abort_groups", n_pulses, 1);

`ifdef CH_START_TIMEOUT_EN
    // Bank 2 never acks: abort 10 cycles after group-2 FIRE, no group-3 start
    set_dly(5);
    dly[2]   = -1;
    n_pulses = 0;
    tgt      = n_done + 1;
    @(negedge clk);
    launch(0, 2, 10, d0);
    wait_done(tgt);
    check("timeout_groups", n_pulses, 3);
    check("timeout_err_held", 32'(timeout_err), 1);
    // Next start clears timeout_err
    set_dly(1);
    n_pulses = 0;
    tgt      = n_done + 1;
    @(negedge clk);
    launch(2, 2, 10, d0);
    wait_done(tgt);
    check("timeout_err_cleared", 32'(timeout_err), 0);
`endif

    // Reset during group-1 WAIT aborts without seq_done; a later start runs from group 0
    set_dly(5);
    n_pulses = 0;
    @(negedge clk);
    launch(0, 2, 0, d0);
    d1 = 0;
    while (n_pulses < 2 && d1 < 200) begin
      @(negedge clk);
      d1++;
    end
    check("reached_group1", n_pulses, 2);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_outputs_zero("abort");
    pulse_q.delete();
    done_q.delete();
    bz_from[0] = 1; bz_to[0] = 0;
    bz_from[1] = 1; bz_to[1] = 0;
    err_on  = BIG;
    err_off = BIG;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tgt  = n_done;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", n_done, tgt);
    set_dly(1);
    n_pulses = 0;
    tgt      = n_done + 1;
    @(negedge clk);
    launch(0, 2, 0, d0);
    wait_done(tgt);
    check("post_reset_groups", n_pulses, 4);

    check("pulse_q_drained", pulse_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
